pingpong_controller: RTL and testbench
======================================

Name: pingpong_controller

Overview:
- Sequences the 2x256-word ping-pong buffer between one streaming producer and one streaming consumer.
- Producer fills the write half through buffer port A; consumer drains the read half through buffer port B.
- Issues the one-cycle `switch` pulse that swaps halves once a block is complete and the previous block has been fully drained.
- Sits between the capture/datapath front-end and the downstream readout logic.

Parameters:
- DEPTH, 256: words per half. Must be ≤256, because the buffer uses an 8-bit in-half address.
- DATA_W, 32: data width; must match the buffer.

Ports:
- clock  in  1  system clock; also clocks the buffer.
- reset  in  1  asynchronous, active-high; also resets the buffer.
- prodValid  in  1  producer word valid.
- prodData  in  DATA_W  producer word.
- prodLast  in  1  marks the final word of a block; qualified by prodValid.
- prodReady  out  1  controller can accept a producer word.
- consValid  out  1  consumer word valid.
- consData  out  DATA_W  consumer word.
- consLast  out  1  final word of the current block.
- consReady  in  1  consumer accepts the word.
- bufAddrA  out  9  buffer port A address.
- bufWeA  out  1  buffer port A write enable.
- bufDataInA  out  DATA_W  buffer port A write data.
- bufAddrB  out  9  buffer port B address.
- bufDataOutB  in  DATA_W  buffer port B read data; 1-cycle synchronous read.
- bufSwitch  out  1  one-cycle swap pulse to the buffer.

Behaviour:
- Reset clocking: reset is asynchronous and active-high; the clock is `clock`.
- Reset values: all outputs are 0 except prodReady, which is 1.
  - Fill state resets to FILL; drain state resets to IDLE.
  - Write pointer, read pointer, in-flight flag, skid FIFO and block-length register all reset to 0.
- Buffer bank select:
  - The buffer selects the bank internally, so bufAddrA[8] and bufAddrB[8] are always 0.
  - The integrator ties buffer writeEnableB and dataInB to 0.
- Producer handshake:
  - A word transfers when prodValid & prodReady.
  - On transfer: bufWeA=1, bufAddrA={0,wptr}, bufDataInA=prodData, all combinational in the same cycle. Then wptr increments.
- Fill FSM:
  - FILL→FULL when a word transfers with prodLast=1 or wptr=DEPTH-1. The block length (wptr+1, 9 bits, range 1..DEPTH) is stored in fillLen.
  - prodReady = (state==FILL).
  - In FULL, prodValid is ignored and no write occurs.
- Swap:
  - bufSwitch=1 for exactly one cycle, when fill==FULL and drain==IDLE.
  - In the same cycle: drainLen<=fillLen, fill→FILL, wptr<=0, drain→DRAIN, rptr<=0.
  - A block completed in cycle N swaps at N+1 at the earliest.
  - A swap never coincides with a producer write.
- Drain FSM:
  - In DRAIN, a read is issued (bufAddrB={0,rptr}) when rptr<drainLen and fifoCount+inflight−pop<2, where pop = consValid&consReady.
  - Data returns the next cycle and is pushed into a 2-entry skid FIFO, together with a last flag set when rptr==drainLen-1.
  - Sustained throughput is 1 word/cycle when consReady is held high.
  - DRAIN→IDLE when all drainLen words have been popped, i.e. the last-flagged word transfers.
  - The swap may occur in the following cycle.
- Consumer outputs:
  - consValid = FIFO non-empty.
  - consData and consLast come from the FIFO head.
  - Stable while consValid & !consReady.
- First block: after reset, drain starts IDLE, so the first completed block swaps immediately.
- Back-pressure: if the consumer stalls, the producer fills the next half and then waits in FULL with prodReady=0. No data is lost or overwritten.
- Reset mid-operation: all blocks in progress or pending are discarded. Both FSMs and the buffer's bank register return to their reset state together.

Decomposition:
- Shared package pingpong_pkg holds:
  - fill-state encoding: FILL, FULL;
  - drain-state encoding: IDLE, DRAIN;
  - constants PP_DEPTH=256 and PP_ADDR_W=8.
- One sub-module, pp_skid_fifo: the 2-entry, DATA_W+1-bit synchronous FIFO with count output.

Test Plan:
- Full block: 256 words (data = index), prodLast on word 255, consReady=1.
  - prodReady drops after word 255.
  - bufSwitch pulses once, the next cycle.
  - consData 0..255 appears in order, with consLast only on 255.
- Short block: 5 words with prodLast on word 4.
  - fillLen=5; exactly 5 words are read out, consLast on the 5th.
  - The unused half contents are never emitted.
- Consumer stall: consReady=0 while producer sends 3 blocks of 16.
  - Block 1 is held at the FIFO head with consValid=1.
  - Block 2 fills; prodReady=0 while block 3 waits.
  - After releasing consReady, all 48 words arrive in order and bufSwitch has pulsed exactly 3 times total.
- Throughput: continuous valid/ready, 64-word blocks.
  - Consumer sees 1 word/cycle within a block.
  - No word is duplicated or dropped across the FIFO back-pressure boundary.
  - Randomly toggle consReady and check the output against a scoreboard.
- Reset mid-drain: assert reset after 10 of 32 words have been read.
  - All outputs return to reset values immediately (asynchronous).
  - After release, a new 4-word block drains correctly, starting at word 0.
- Bank alternation: two consecutive blocks with distinct data (0xA000.., 0xB000..).
  - Reads return the correct block each time.
  - bufAddrA[8] and bufAddrB[8] are always 0.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared encodings and sizing constants for the ping-pong buffer controller.
package pingpong_pkg;

   localparam int PP_DEPTH  = 256;
   localparam int PP_ADDR_W = 8;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } fill_state_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

endpackage

// File: rtl/pp_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs read data returning from the buffer
// while the consumer stalls; exposes its occupancy for read issue control.
module pp_skid_fifo #(
   parameter int W = 33
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   // NOTE: the two storage words are reset too, so the consumer data bus reads
   // 0 out of reset instead of whatever the flops powered up with.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pingpong_controller.sv
// Ping-pong buffer sequencer: producer fills one half over port A, consumer
// drains the other over port B, and halves swap once both sides are ready.
module pingpong_controller
   import pingpong_pkg::*;
#(
   parameter int DEPTH  = PP_DEPTH,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prodValid,
   input  logic [DATA_W-1:0] prodData,
   input  logic              prodLast,
   output logic              prodReady,
   output logic              consValid,
   output logic [DATA_W-1:0] consData,
   output logic              consLast,
   input  logic              consReady,
   output logic [8:0]        bufAddrA,
   output logic              bufWeA,
   output logic [DATA_W-1:0] bufDataInA,
   output logic [8:0]        bufAddrB,
   input  logic [DATA_W-1:0] bufDataOutB,
   output logic              bufSwitch
);

   localparam int LEN_W = PP_ADDR_W + 1;
   localparam logic [PP_ADDR_W-1:0] WPTR_MAX = PP_ADDR_W'(DEPTH - 1);

   fill_state_t          fill_state, fill_next;
   drain_state_t         drain_state, drain_next;
   logic [PP_ADDR_W-1:0] wptr;
   logic [LEN_W-1:0]     rptr;
   logic [LEN_W-1:0]     fill_len;
   logic [LEN_W-1:0]     drain_len;
   logic                 inflight;
   logic                 inflight_last;

   logic                 prod_fire;
   logic                 block_done;
   logic                 swap;
   logic                 pop;
   logic                 rd_issue;
   logic [1:0]           fifo_count;
   logic [DATA_W:0]      fifo_head;

   assign consValid = (fifo_count != 2'd0);
   assign consData  = fifo_head[DATA_W-1:0];
   assign consLast  = fifo_head[DATA_W];
   assign pop       = consValid & consReady;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      fill_next  = fill_state;
      drain_next = drain_state;
      prodReady  = (fill_state == FILL);
      prod_fire  = prodValid & prodReady;
      block_done = prod_fire & (prodLast | (wptr == WPTR_MAX));
      swap       = (fill_state == FULL) && (drain_state == IDLE);
      // Issue only if the returning word is guaranteed a FIFO slot.
      rd_issue   = (drain_state == DRAIN) && (rptr < drain_len) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

      unique case (fill_state)
         FILL:    if (block_done) fill_next = FULL;
         FULL:    if (swap)       fill_next = FILL;
         default: fill_next = FILL;
      endcase

      unique case (drain_state)
         IDLE:    if (swap)            drain_next = DRAIN;
         DRAIN:   if (pop && consLast) drain_next = IDLE;
         default: drain_next = IDLE;
      endcase
   end

   assign bufSwitch  = swap;
   assign bufWeA     = prod_fire;
   assign bufAddrA   = {1'b0, wptr};
   assign bufDataInA = prod_fire ? prodData : '0;
   assign bufAddrB   = {1'b0, rptr[PP_ADDR_W-1:0]};

   // NOTE: all state below updates with non-blocking assignments so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fill_state  <= FILL;
         drain_state <= IDLE;
      end else begin
         fill_state  <= fill_next;
         drain_state <= drain_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr          <= '0;
         rptr          <= '0;
         fill_len      <= '0;
         drain_len     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         if (swap)           wptr <= '0;
         else if (prod_fire) wptr <= wptr + 1'b1;

         if (block_done) fill_len <= {1'b0, wptr} + 1'b1;

         if (swap) begin
            drain_len <= fill_len;
            rptr      <= '0;
         end else if (rd_issue) begin
            rptr <= rptr + 1'b1;
         end

         inflight      <= rd_issue;
         inflight_last <= rd_issue && (rptr == drain_len - 1'b1);
      end
   end

   pp_skid_fifo #(
      .W (DATA_W + 1)
   ) u_skid_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (inflight),
      .push_data ({inflight_last, bufDataOutB}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_pingpong_controller.sv
// Self-checking bench for pingpong_controller with a behavioural ping-pong
// buffer and a block-splitting reference model of the consumer stream.
module tb_pingpong_controller;

   localparam int DEPTH  = 256;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              prodValid = 1'b0;
   logic [DATA_W-1:0] prodData = '0;
   logic              prodLast = 1'b0;
   logic              prodReady;
   logic              consValid;
   logic [DATA_W-1:0] consData;
   logic              consLast;
   logic              consReady = 1'b0;
   logic [8:0]        bufAddrA;
   logic              bufWeA;
   logic [DATA_W-1:0] bufDataInA;
   logic [8:0]        bufAddrB;
   logic [DATA_W-1:0] bufDataOutB;
   logic              bufSwitch;

   always #5 clock = ~clock;

   pingpong_controller #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .prodValid   (prodValid),
      .prodData    (prodData),
      .prodLast    (prodLast),
      .prodReady   (prodReady),
      .consValid   (consValid),
      .consData    (consData),
      .consLast    (consLast),
      .consReady   (consReady),
      .bufAddrA    (bufAddrA),
      .bufWeA      (bufWeA),
      .bufDataInA  (bufDataInA),
      .bufAddrB    (bufAddrB),
      .bufDataOutB (bufDataOutB),
      .bufSwitch   (bufSwitch)
   );

   // Ping-pong buffer: port A writes the current bank, port B reads the other.
   logic [DATA_W-1:0] buf_mem [2][256];
   logic              bank;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bank        <= 1'b0;
         bufDataOutB <= '0;
      end else begin
         if (bufWeA) buf_mem[bank][bufAddrA[7:0]] <= bufDataInA;
         bufDataOutB <= buf_mem[~bank][bufAddrB[7:0]];
         if (bufSwitch) bank <= ~bank;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // {last, data} words
   logic [DATA_W:0] prod_q [$];
   logic [DATA_W:0] exp_q [$];
   logic [DATA_W:0] rx_q [$];
   int              model_cnt = 0;

   int              cons_mode = 0;   // 0 ready, 1 stalled, 2 random
   int              prod_gap  = 0;   // percent of cycles producer idles
   int              cyc = 0;
   int              switch_cnt = 0;
   int              msb_err = 0;
   int              stall_err = 0;
   int              gap_err = 0;
   bit              tput_chk = 1'b0;
   bit              prev_stall = 1'b0;
   bit              have_prev_pop = 1'b0;
   bit              prev_pop_last = 1'b0;
   int              prev_pop_cyc = 0;
   logic [DATA_W:0] prev_head = '0;

   // Reference model: a block ends on prodLast or after DEPTH words.
   task automatic enqueue(input logic [DATA_W-1:0] d, input logic last);
      logic end_blk;
      end_blk = last || (model_cnt == DEPTH - 1);
      prod_q.push_back({last, d});
      exp_q.push_back({end_blk, d});
      model_cnt = end_blk ? 0 : model_cnt + 1;
   endtask

   task automatic tick();
      logic [DATA_W:0] w;
      @(posedge clock);
      #1;
      cyc++;
      if (prod_q.size() > 0 && $urandom_range(99) >= prod_gap) begin
         w         = prod_q[0];
         prodValid = 1'b1;
         prodData  = w[DATA_W-1:0];
         prodLast  = w[DATA_W];
      end else begin
         prodValid = 1'b0;
         prodData  = '0;
         prodLast  = 1'b0;
      end
      consReady = (cons_mode == 0) ? 1'b1 : (cons_mode == 1) ? 1'b0 : 1'($urandom_range(1));
      #1;
      if (prodValid && prodReady) void'(prod_q.pop_front());
      if (prev_stall && !(consValid && ({consLast, consData} == prev_head))) stall_err++;
      prev_stall = consValid && !consReady;
      prev_head  = {consLast, consData};
      if (consValid && consReady) begin
         if (tput_chk && have_prev_pop && !prev_pop_last && cyc != prev_pop_cyc + 1) gap_err++;
         have_prev_pop = 1'b1;
         prev_pop_last = consLast;
         prev_pop_cyc  = cyc;
         rx_q.push_back({consLast, consData});
      end
      if (bufSwitch) switch_cnt++;
      if (bufAddrA[8] || bufAddrB[8]) msb_err++;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int b = 0;
      while (rx_q.size() < n && b < budget) begin
         tick();
         b++;
      end
      repeat (20) tick();
   endtask

   task automatic start_scenario();
      rx_q.delete();
      exp_q.delete();
      model_cnt  = 0;
      switch_cnt = 0;
   endtask

   task automatic compare_stream(input string name);
      int errs = 0;
      int n;
      check({name, "_len"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (rx_q[i] !== exp_q[i]) errs++;
      check({name, "_data"}, errs, 0);
   endtask

   typedef struct {
      int          n_blocks;
      int          len;
      bit          mark_last;
      logic [31:0] base;
      int          exp_words;
      int          exp_switches;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [DATA_W:0] head_exp;
      int              b;

      vecs[0] = '{1,   5, 1'b1, 32'h0000_0100,   5, 1};  // short block
      vecs[1] = '{1, 256, 1'b0, 32'h0000_1000, 256, 1};  // ends at DEPTH only
      vecs[2] = '{3,   1, 1'b1, 32'h0000_2000,   3, 3};  // one-word blocks
      vecs[3] = '{2,   8, 1'b1, 32'h0000_A000,  16, 2};  // bank alternation
      vecs[4] = '{1, 255, 1'b1, 32'h0003_0000, 255, 1};  // one short of full

      // Reset values
      #12;
      check("rst_prodReady", prodReady, 1);
      check("rst_consValid", consValid, 0);
      check("rst_consData", consData, 0);
      check("rst_consLast", consLast, 0);
      check("rst_bufWeA", bufWeA, 0);
      check("rst_bufAddrA", bufAddrA, 0);
      check("rst_bufAddrB", bufAddrB, 0);
      check("rst_bufSwitch", bufSwitch, 0);
      @(negedge clock);
      reset = 1'b0;

      // Full 256-word block
      start_scenario();
      cons_mode = 0;
      for (int i = 0; i < 256; i++) enqueue(DATA_W'(i), i == 255);
      b = 0;
      while (prod_q.size() > 0 && b < 1000) begin
         tick();
         b++;
      end
      check("full_accepted", prod_q.size(), 0);
      check("full_no_early_switch", bufSwitch, 0);
      tick();
      check("full_prodReady_drop", prodReady, 0);
      check("full_switch_pulse", bufSwitch, 1);
      tick();
      check("full_switch_one_cycle", bufSwitch, 0);
      wait_rx(256, 1000);
      check("full_switch_count", switch_cnt, 1);
      compare_stream("full");

      // Table-driven block shapes
      for (int v = 0; v < 5; v++) begin
         start_scenario();
         for (int bl = 0; bl < vecs[v].n_blocks; bl++)
            for (int i = 0; i < vecs[v].len; i++)
               enqueue(vecs[v].base + 32'(bl * 4096 + i),
                       vecs[v].mark_last && (i == vecs[v].len - 1));
         wait_rx(vecs[v].exp_words, 3000);
         check($sformatf("vec%0d_words", v), rx_q.size(), vecs[v].exp_words);
         check($sformatf("vec%0d_switches", v), switch_cnt, vecs[v].exp_switches);
         compare_stream($sformatf("vec%0d", v));
      end

      // Consumer stall with three 16-word blocks
      start_scenario();
      cons_mode = 1;
      for (int bl = 0; bl < 3; bl++)
         for (int i = 0; i < 16; i++) enqueue(32'h5000 + 32'(bl * 256 + i), i == 15);
      repeat (100) tick();
      head_exp = exp_q[0];
      check("stall_consValid", consValid, 1);
      check("stall_head", {consLast, consData}, head_exp);
      check("stall_prodReady", prodReady, 0);
      check("stall_block3_waiting", prod_q.size(), 16);
      check("stall_switch_count", switch_cnt, 1);
      cons_mode = 0;
      wait_rx(48, 1000);
      check("stall_total_switches", switch_cnt, 3);
      compare_stream("stall");

      // Throughput: continuous 64-word blocks
      start_scenario();
      have_prev_pop = 1'b0;
      tput_chk      = 1'b1;
      for (int bl = 0; bl < 4; bl++)
         for (int i = 0; i < 64; i++) enqueue($urandom, i == 63);
      wait_rx(256, 3000);
      tput_chk = 1'b0;
      check("tput_gaps", gap_err, 0);
      compare_stream("tput");

      // Random ready / valid against the model
      start_scenario();
      cons_mode = 2;
      prod_gap  = 30;
      for (int k = 0; k < 600; k++)
         enqueue($urandom, (k >= 300 && $urandom_range(19) == 0) || k == 599);
      wait_rx(600, 20000);
      compare_stream("random");
      cons_mode = 0;
      prod_gap  = 0;

      // Reset in the middle of a drain
      start_scenario();
      for (int i = 0; i < 32; i++) enqueue(32'h7000 + 32'(i), i == 31);
      b = 0;
      while (rx_q.size() < 10 && b < 1000) begin
         tick();
         b++;
      end
      check("mid_rx_before_reset", rx_q.size(), 10);
      prodValid = 1'b0;
      prodData  = '0;
      prodLast  = 1'b0;
      reset     = 1'b1;
      #1;
      check("mid_prodReady", prodReady, 1);
      check("mid_consValid", consValid, 0);
      check("mid_consData", consData, 0);
      check("mid_consLast", consLast, 0);
      check("mid_bufAddrB", bufAddrB, 0);
      check("mid_bufSwitch", bufSwitch, 0);
      prod_q.delete();
      start_scenario();
      prev_stall    = 1'b0;
      have_prev_pop = 1'b0;
      @(posedge clock);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) enqueue(32'hC000 + 32'(i), i == 3);
      wait_rx(4, 500);
      check("post_reset_switches", switch_cnt, 1);
      compare_stream("post_reset");

      check("bank_msb_zero", msb_err, 0);
      check("stall_stability", stall_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
